keypad_scanner: RTL

Scans the 4x4 operator keypad, debounces it, and presents one accepted key per press to the wire-cutter control FSM. It sits directly upstream of the control FSM, which acts on `key` only in a cycle where `onOff==1 && delay==0`. The block therefore guarantees exactly one such cycle per debounced press. All outputs are registered, so they can be used directly in the downstream clock domain (same `clk`).

---
 rtl/keypad_scanner.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row sequencing, column synchronization, frame debounce,
// and one-shot acceptance of each debounced press for the wire-cutter control FSM.
module keypad_scanner #(
  parameter int unsigned FCLK            = 50000000,
  parameter int unsigned SCAN_HZ         = 1000,
  parameter int unsigned DEBOUNCE_FRAMES = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key,
  output logic       onOff,
  output logic       delay
);

  localparam int unsigned ROW_DWELL = FCLK / SCAN_HZ;
  localparam int unsigned DW_W      = $clog2(ROW_DWELL);
  localparam int unsigned CNT_W     = $clog2(DEBOUNCE_FRAMES + 1);

  typedef enum logic {ST_IDLE, ST_PRESSED} state_t;

  logic [3:0]       r_col_s1, r_col_s2;
  logic [1:0]       r_idx;
  logic [DW_W-1:0]  r_dwell;
  logic [3:0]       r_row;
  logic             r_found;
  logic [3:0]       r_found_pos;
  logic [4:0]       r_cand;
  logic [CNT_W-1:0] r_cnt;
  state_t           r_state;
  logic [3:0]       r_key;
  logic             r_on_off;
  logic             r_delay;

  logic             w_last_dwell;
  logic [1:0]       w_idx_next;
  logic             w_row_hit;
  logic [1:0]       w_row_col;
  logic             w_frame_found;
  logic [3:0]       w_frame_pos;
  logic [4:0]       w_raw;
  logic             w_stable;

  assign row   = r_row;
  assign key   = r_key;
  assign onOff = r_on_off;
  assign delay = r_delay;

  // Position index {row, col} to operator key code.
  function automatic logic [3:0] key_code(input logic [3:0] pos);
    case (pos)
      4'd0:  key_code = 4'd1;
      4'd1:  key_code = 4'd2;
      4'd2:  key_code = 4'd3;
      4'd3:  key_code = 4'd10;
      4'd4:  key_code = 4'd4;
      4'd5:  key_code = 4'd5;
      4'd6:  key_code = 4'd6;
      4'd7:  key_code = 4'd11;
      4'd8:  key_code = 4'd7;
      4'd9:  key_code = 4'd8;
      4'd10: key_code = 4'd9;
      4'd11: key_code = 4'd12;
      4'd12: key_code = 4'd14;
      4'd13: key_code = 4'd0;
      4'd14: key_code = 4'd13;
      default: key_code = 4'd15;
    endcase
  endfunction

  assign w_last_dwell = (r_dwell == DW_W'(ROW_DWELL - 1));
  assign w_idx_next   = w_last_dwell ? r_idx + 2'd1 : r_idx;
  assign w_row_hit    = (r_col_s2 != 4'b1111);
  assign w_stable     = (r_cnt == CNT_W'(DEBOUNCE_FRAMES));

  // Lowest pressed column in the current row; earlier rows of the frame win.
  always_comb begin
    w_row_col = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!r_col_s2[i]) w_row_col = 2'(i);
    end
    if ((r_idx != 2'd0) && r_found) begin
      w_frame_found = 1'b1;
      w_frame_pos   = r_found_pos;
    end else begin
      w_frame_found = w_row_hit;
      w_frame_pos   = {r_idx, w_row_col};
    end
    w_raw = w_frame_found ? {1'b1, w_frame_pos} : 5'd0;
  end

  // Column synchronizer and row scan sequencer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_col_s1 <= 4'b1111;
      r_col_s2 <= 4'b1111;
      r_dwell  <= '0;
      r_idx    <= 2'd0;
      r_row    <= 4'b1111;
    end else begin
      r_col_s1 <= col;
      r_col_s2 <= r_col_s1;
      r_dwell  <= w_last_dwell ? '0 : r_dwell + DW_W'(1);
      r_idx    <= w_idx_next;
      r_row    <= ~(4'b0001 << w_idx_next);
    end
  end

  // Per-frame result accumulation and frame-level debounce.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_found     <= 1'b0;
      r_found_pos <= 4'd0;
      r_cand      <= 5'd0;
      r_cnt       <= '0;
    end else if (w_last_dwell) begin
      r_found     <= w_frame_found;
      r_found_pos <= w_frame_pos;
      if (r_idx == 2'd3) begin
        if (w_raw == r_cand) begin
          if (!w_stable) r_cnt <= r_cnt + CNT_W'(1);
        end else begin
          r_cand <= w_raw;
          r_cnt  <= CNT_W'(1);
        end
      end
    end
  end

  // Acceptance: one delay pulse per press, release required before the next key.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_key    <= 4'd0;
      r_on_off <= 1'b0;
      r_delay  <= 1'b1;
    end else begin
      r_delay <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (r_cand[4] && w_stable) begin
            r_key    <= key_code(r_cand[3:0]);
            r_on_off <= 1'b1;
            r_delay  <= 1'b0;
            r_state  <= ST_PRESSED;
          end
        end
        default: begin
          if (!r_cand[4] && w_stable) begin
            r_on_off <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
